// File: rtl/fpnew_result_collector.sv
// Round-robin collector of opgroup result channels into a small output FIFO,
// with sticky accumulated fflags and an FPU-level busy indication.
module fpnew_result_collector #(
  parameter int unsigned NumIn    = 4,
  parameter int unsigned Width    = 64,
  parameter int unsigned TagWidth = 8,
  parameter int unsigned Depth    = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [NumIn-1:0]           in_valid_i,
  output logic [NumIn-1:0]           in_ready_o,
  input  logic [NumIn*Width-1:0]     in_result_i,
  input  logic [NumIn*5-1:0]         in_status_i,
  input  logic [NumIn-1:0]           in_ext_bit_i,
  input  logic [NumIn*TagWidth-1:0]  in_tag_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [Width-1:0]           out_result_o,
  output logic [4:0]                 out_status_o,
  output logic                       out_ext_bit_o,
  output logic [TagWidth-1:0]        out_tag_o,
  output logic [4:0]                 fflags_o,
  input  logic                       fflags_clr_i,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       busy_o
);

  localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef struct packed {
    logic [Width-1:0]    result;
    logic [4:0]          status;
    logic                ext_bit;
    logic [TagWidth-1:0] tag;
  } entry_t;

  entry_t          mem_q [Depth];
  entry_t          head;
  entry_t          in_entry;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [4:0]      fflags_q, fflags_d;
  logic [IdxW-1:0] grant_idx, cand_idx;
  logic            grant_valid;
  logic            pop, pop_eff, space, push;
  int unsigned     cand;

  assign head        = mem_q[rd_ptr_q];
  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o & out_ready_i;
  assign pop_eff     = pop & ~flush_i;
  assign space       = (count_q < CntW'(Depth)) | pop;
  assign push        = grant_valid & space & ~flush_i & rst_ni;

  // Rotating-priority search starting at the round-robin pointer.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      cand     = (32'(rr_ptr_q) + k) % NumIn;
      cand_idx = IdxW'(cand);
      if (!grant_valid && in_valid_i[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign in_ready_o = push ? (NumIn'(1) << grant_idx) : '0;

  always_comb begin
    in_entry.result  = in_result_i[grant_idx*Width +: Width];
    in_entry.status  = in_status_i[grant_idx*5 +: 5];
    in_entry.ext_bit = in_ext_bit_i[grant_idx];
    in_entry.tag     = in_tag_i[grant_idx*TagWidth +: TagWidth];
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    fflags_d = fflags_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      rr_ptr_d = (grant_idx == IdxW'(NumIn - 1)) ? '0 : grant_idx + IdxW'(1);
    end
    if (pop_eff) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      fflags_d = fflags_q | head.status;
    end
    if (push && !pop_eff) count_d = count_q + CntW'(1);
    if (!push && pop_eff) count_d = count_q - CntW'(1);
    // A clear coinciding with a pop keeps the retiring result's flags.
    if (fflags_clr_i) fflags_d = pop_eff ? head.status : 5'b0;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      rr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
      fflags_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      fflags_q <= fflags_d;
    end
  end

  // Payload storage needs no reset: it is only visible while out_valid_o is set.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  assign out_result_o  = out_valid_o ? head.result  : '0;
  assign out_status_o  = out_valid_o ? head.status  : '0;
  assign out_ext_bit_o = out_valid_o ? head.ext_bit : 1'b0;
  assign out_tag_o     = out_valid_o ? head.tag     : '0;
  assign fflags_o      = fflags_q;
  assign count_o       = count_q;
  assign busy_o        = (|in_valid_i) | out_valid_o;

`ifndef SYNTHESIS
  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(in_ready_o));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push && count_q == CntW'(Depth)) |-> pop);
  a_head_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_o && !out_ready_i && !flush_i) |=>
      (out_valid_o && $stable(out_result_o) && $stable(out_status_o) &&
       $stable(out_ext_bit_o) && $stable(out_tag_o)));
`endif

endmodule

// File: tb/tb_fpnew_result_collector.sv
// Directed bench for fpnew_result_collector: queue-based reference model checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_fpnew_result_collector;

  localparam int NI = 4;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [3:0]    in_valid;
  logic [3:0]    in_ready;
  logic [255:0]  in_result;
  logic [19:0]   in_status;
  logic [3:0]    in_ext;
  logic [31:0]   in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_result;
  logic [4:0]    out_status;
  logic          out_ext;
  logic [7:0]    out_tag;
  logic [4:0]    fflags;
  logic          fclr;
  logic [1:0]    count;
  logic          busy;

  int checks = 0;
  int passes = 0;

  fpnew_result_collector #(.NumIn(4), .Width(64), .TagWidth(8), .Depth(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_result_i(in_result),
    .in_status_i(in_status), .in_ext_bit_i(in_ext), .in_tag_i(in_tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_result_o(out_result),
    .out_status_o(out_status), .out_ext_bit_o(out_ext), .out_tag_o(out_tag),
    .fflags_o(fflags), .fflags_clr_i(fclr), .count_o(count), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else passes++;
  endtask

  task automatic set_ch(input int i, input logic [63:0] r, input logic [4:0] s,
                        input logic e, input logic [7:0] t);
    in_result[i*64 +: 64] = r;
    in_status[i*5 +: 5]   = s;
    in_ext[i]             = e;
    in_tag[i*8 +: 8]      = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: FIFO as a queue, RR pointer as an integer, sticky flags.
  typedef struct {
    logic [63:0] res;
    logic [4:0]  st;
    logic        ext;
    logic [7:0]  tag;
  } ent_t;

  ent_t        mq[$];
  int          mptr = 0;
  logic [4:0]  mff = '0;

  always @(negedge clk) begin
    int          g;
    int          c;
    logic [3:0]  er;
    logic        mpop;
    ent_t        e;
    if (!rst_n) begin
      mq.delete();
      mptr = 0;
      mff  = '0;
    end
    g = -1;
    if (rst_n && !flush && (mq.size() < DEPTH || (mq.size() > 0 && out_ready))) begin
      for (int k = 0; k < NI; k++) begin
        c = (mptr + k) % NI;
        if (g < 0 && in_valid[c]) g = c;
      end
    end
    er = (g >= 0) ? (4'(1) << g) : 4'b0;
    chk("m_in_ready", 64'(in_ready), 64'(er));
    chk("m_count", 64'(count), 64'(mq.size()));
    chk("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("m_fflags", 64'(fflags), 64'(mff));
    chk("m_busy", 64'(busy), 64'((|in_valid) || mq.size() > 0));
    if (mq.size() > 0) begin
      chk("m_out_result", out_result, mq[0].res);
      chk("m_out_status", 64'(out_status), 64'(mq[0].st));
      chk("m_out_ext", 64'(out_ext), 64'(mq[0].ext));
      chk("m_out_tag", 64'(out_tag), 64'(mq[0].tag));
    end else begin
      chk("m_out_zero", {out_result[55:0], out_tag}, 64'(0));
    end
    if (rst_n) begin
      mpop = (mq.size() > 0) && out_ready && !flush;
      if (fclr) mff = mpop ? mq[0].st : 5'b0;
      else if (mpop) mff = mff | mq[0].st;
      if (flush) begin
        mq.delete();
        mptr = 0;
      end else begin
        if (mpop) void'(mq.pop_front());
        if (g >= 0) begin
          e.res = in_result[g*64 +: 64];
          e.st  = in_status[g*5 +: 5];
          e.ext = in_ext[g];
          e.tag = in_tag[g*8 +: 8];
          mq.push_back(e);
          mptr = (g + 1) % NI;
        end
      end
    end
  end

  initial begin
    int gexp[8] = '{3, 0, 1, 2, 3, 0, 1, 2};
    rst_n = 1'b0; flush = 1'b0; in_valid = '0; out_ready = 1'b0; fclr = 1'b0;
    in_result = '0; in_status = '0; in_ext = '0; in_tag = '0;
    #2;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_fflags", 64'(fflags), 64'(0));
    chk("rst_busy_idle", 64'(busy), 64'(0));
    in_valid = 4'b0010;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_busy_req", 64'(busy), 64'(1));
    in_valid = '0;
    tick();
    rst_n = 1'b1;

    // Single push on ch2
    tick();
    set_ch(2, 64'h3FF0_0000_0000_0000, 5'b00001, 1'b1, 8'h11);
    in_valid = 4'b0100; out_ready = 1'b1;
    #1;
    chk("single_grant", 64'(in_ready), 64'(4'b0100));
    tick();
    in_valid = '0;
    #1;
    chk("single_valid", 64'(out_valid), 64'(1));
    chk("single_result", out_result, 64'h3FF0_0000_0000_0000);
    chk("single_status", 64'(out_status), 64'(5'b00001));
    chk("single_ext", 64'(out_ext), 64'(1));
    chk("single_tag", 64'(out_tag), 64'(8'h11));
    tick();
    #1;
    chk("single_fflags", 64'(fflags), 64'(5'b00001));
    chk("single_count", 64'(count), 64'(0));

    // Round-robin with every channel requesting (pointer left at 3)
    tick();
    for (int i = 0; i < NI; i++) set_ch(i, 64'(i + 100), 5'b0, 1'b0, 8'(8'h20 + i));
    in_valid = 4'b1111;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("rr_grant", 64'(in_ready), 64'(4'(1) << gexp[k]));
      tick();
      #1;
    end
    in_valid = '0;
    tick();
    #1;
    chk("rr_drain", 64'(count), 64'(0));

    // Backpressure until full, then simultaneous pop and push
    tick();
    fclr = 1'b1; out_ready = 1'b0;
    set_ch(0, 64'hA0, 5'b10000, 1'b0, 8'h30);
    set_ch(1, 64'hA1, 5'b00100, 1'b1, 8'h31);
    in_valid = 4'b0011;
    #1;
    chk("bp_grant0", 64'(in_ready), 64'(4'b0001));
    tick();
    fclr = 1'b0;
    #1;
    chk("bp_grant1", 64'(in_ready), 64'(4'b0010));
    chk("bp_head0", 64'(out_tag), 64'(8'h30));
    tick();
    #1;
    chk("bp_full_count", 64'(count), 64'(2));
    chk("bp_full_ready", 64'(in_ready), 64'(0));
    chk("bp_fflags_clr", 64'(fflags), 64'(0));
    tick();
    #1;
    chk("bp_head_hold", 64'(out_tag), 64'(8'h30));
    set_ch(0, 64'hA2, 5'b10000, 1'b0, 8'h32);
    out_ready = 1'b1;
    #1;
    chk("bp_poppush_grant", 64'(in_ready), 64'(4'b0001));
    tick();
    out_ready = 1'b0; in_valid = '0;
    #1;
    chk("bp_poppush_count", 64'(count), 64'(2));
    chk("bp_new_head", 64'(out_tag), 64'(8'h31));
    chk("bp_fflags", 64'(fflags), 64'(5'b10000));

    // Clear colliding with a pop keeps the retiring status
    out_ready = 1'b1; fclr = 1'b1;
    tick();
    fclr = 1'b0; out_ready = 1'b0;
    #1;
    chk("clr_pop_fflags", 64'(fflags), 64'(5'b00100));
    chk("clr_pop_count", 64'(count), 64'(1));

    // Fill to two with pointer at 3, then flush
    set_ch(2, 64'hB2, 5'b0, 1'b0, 8'h40);
    in_valid = 4'b0100;
    #1;
    chk("fl_fill_grant", 64'(in_ready), 64'(4'b0100));
    tick();
    set_ch(1, 64'hB1, 5'b00010, 1'b0, 8'h41);
    in_valid = 4'b0010; flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("fl_ready_zero", 64'(in_ready), 64'(0));
    chk("fl_count_before", 64'(count), 64'(2));
    tick();
    flush = 1'b0; out_ready = 1'b0;
    set_ch(3, 64'hB3, 5'b01000, 1'b1, 8'h43);
    in_valid = 4'b1010;
    #1;
    chk("fl_count", 64'(count), 64'(0));
    chk("fl_out_valid", 64'(out_valid), 64'(0));
    chk("fl_fflags_kept", 64'(fflags), 64'(5'b00100));
    chk("fl_grant_from0", 64'(in_ready), 64'(4'b0010));

    // Fill to full, then asynchronous reset between edges
    tick();
    #1;
    chk("ar_grant3", 64'(in_ready), 64'(4'b1000));
    tick();
    #1;
    chk("ar_full", 64'(count), 64'(2));
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'(0));
    chk("ar_count", 64'(count), 64'(0));
    chk("ar_fflags", 64'(fflags), 64'(0));
    chk("ar_in_ready", 64'(in_ready), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("ar_grant_from0", 64'(in_ready), 64'(4'b0010));
    tick();
    in_valid = '0; out_ready = 1'b1;
    tick();
    tick();
    #1;
    chk("end_count", 64'(count), 64'(0));
    chk("end_fflags", 64'(fflags), 64'(5'b00010));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
